// File: rtl/defparam_check_pkg.sv
// Shared types and widths for the defparam result checker.
package defparam_check_pkg;
    typedef enum logic [1:0] {IDLE, CHECK, PASS, FAIL} state_e;
    localparam int MASK_W = 3;
    localparam int CNT_W  = 16;
endpackage

// File: rtl/defparam_word_cmp.sv
// Full-width compare of the three observed words against their expected values.
// Purely combinational; a set bit in miss_o marks a word that differs this cycle.
module defparam_word_cmp
    import defparam_check_pkg::*;
#(
    parameter int unsigned     W    = 32,
    parameter logic [W-1:0]    EXP2 = W'(8),
    parameter logic [W-1:0]    EXP3 = W'(80),
    parameter logic [W-1:0]    EXP4 = W'(400)
) (
    input  logic [W-1:0]      o2_i,
    input  logic [W-1:0]      o3_i,
    input  logic [W-1:0]      o4_i,
    output logic [MASK_W-1:0] miss_o
);
    assign miss_o = {o4_i != EXP4, o3_i != EXP3, o2_i != EXP2};
endmodule

// File: rtl/defparam_result_checker.sv
// After start, requires STABLE_CYCLES consecutive matching cycles (earliest PASS STABLE_CYCLES
// cycles after start) or FAILs at TIMEOUT; DEFPARAM_CHECK_FINISH_EN adds finish/stop on verdict.
module defparam_result_checker
    import defparam_check_pkg::*;
#(
    parameter int unsigned  W             = 32,
    parameter logic [W-1:0] EXP2          = W'(8),
    parameter logic [W-1:0] EXP3          = W'(80),
    parameter logic [W-1:0] EXP4          = W'(400),
    parameter int unsigned  STABLE_CYCLES = 4,
    parameter int unsigned  TIMEOUT       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [W-1:0]      o2,
    input  logic [W-1:0]      o3,
    input  logic [W-1:0]      o4,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [MASK_W-1:0] mismatch_mask,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
);
    state_e              state_q;
    logic [MASK_W-1:0]   mask_q;
    logic [CNT_W-1:0]    mcnt_q;
    logic [CNT_W-1:0]    ccnt_q;
    logic [CNT_W-1:0]    stable_q;

    logic [MASK_W-1:0]   miss;
    logic                match;
    logic                pass_cond;
    logic                timeout;
    logic [CNT_W-1:0]    mcnt_d;
    logic [MASK_W-1:0]   mask_d;

    defparam_word_cmp #(
        .W    (W),
        .EXP2 (EXP2),
        .EXP3 (EXP3),
        .EXP4 (EXP4)
    ) u_cmp (
        .o2_i   (o2),
        .o3_i   (o3),
        .o4_i   (o4),
        .miss_o (miss)
    );

    assign match     = (miss == '0);
    assign pass_cond = match && (stable_q == CNT_W'(STABLE_CYCLES - 1));
    assign timeout   = (ccnt_q == CNT_W'(TIMEOUT - 1));
    assign mcnt_d    = (mcnt_q == '1) ? mcnt_q : mcnt_q + 1'b1;
    assign mask_d    = mask_q | miss;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            mcnt_q   <= '0;
            ccnt_q   <= '0;
            stable_q <= '0;
        end else begin
            case (state_q)
                CHECK: begin
                    if (match) begin
                        stable_q <= stable_q + 1'b1;
                    end else begin
                        stable_q <= '0;
                        mcnt_q   <= mcnt_d;
                        mask_q   <= mask_d;
                    end
                    // PASS takes priority when the last stable cycle lands on the timeout cycle.
                    if (pass_cond) begin
                        state_q <= PASS;
`ifdef DEFPARAM_CHECK_FINISH_EN
                        $write("*-* All Finished *-*\n");
                        $finish;
`endif
                    end else if (timeout) begin
                        state_q <= FAIL;
`ifdef DEFPARAM_CHECK_FINISH_EN
                        $display("defparam check failed: mismatch_mask=%b mismatch_cnt=%0d",
                                 match ? mask_q : mask_d, match ? mcnt_q : mcnt_d);
                        $stop;
`endif
                    end else begin
                        ccnt_q <= ccnt_q + 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_q  <= CHECK;
                        mask_q   <= '0;
                        mcnt_q   <= '0;
                        ccnt_q   <= '0;
                        stable_q <= '0;
                    end
                end
            endcase
        end
    end

    assign busy          = (state_q == CHECK);
    assign pass          = (state_q == PASS);
    assign fail          = (state_q == FAIL);
    assign done          = pass | fail;
    assign mismatch_mask = mask_q;
    assign mismatch_cnt  = mcnt_q;
    assign cycle_cnt     = ccnt_q;
endmodule
